// File: rtl/borrow_ahead_pkg.sv
// Shared definitions for the digit-serial borrow-lookahead subtractor:
// slice width, controller state encoding and step-count helper.
package borrow_ahead_pkg;

   localparam int SLICE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Number of slice steps needed to cover an operand of the given width.
   function automatic int steps(input int width);
      return width / SLICE_W;
   endfunction

endpackage

// File: rtl/borrow_ahead_slice.sv
// Purely combinational 4-bit subtract slice: d = a - b - bi, with every
// internal borrow expanded in lookahead form from per-bit generate/propagate.
module borrow_ahead_slice
   import borrow_ahead_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               bi,
   output logic [SLICE_W-1:0] d,
   output logic               bo
);

   logic [SLICE_W-1:0] g;
   logic [SLICE_W-1:0] p;
   logic [SLICE_W:0]   c;

   // g: this bit borrows on its own; p: this bit passes an incoming borrow on.
   assign g = ~a & b;
   assign p = ~(a ^ b);

   always_comb begin
      c    = '0;
      c[0] = bi;
      c[1] = g[0] | (p[0] & bi);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & bi);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & bi);
   end

   assign d  = a ^ b ^ c[SLICE_W-1:0];
   assign bo = c[SLICE_W];

endmodule

// File: rtl/borrow_ahead_sub_seq.sv
// Digit-serial subtractor D = A - B - Bin, one 4-bit lookahead slice per clock.
// Optional signed-overflow output V is enabled by BORROW_AHEAD_SUB_SEQ_OVF_EN.
module borrow_ahead_sub_seq
   import borrow_ahead_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] D,
   output logic             Bout,
`ifdef BORROW_AHEAD_SUB_SEQ_OVF_EN
   output logic             V,
`endif
   output logic [1:0]       dbg_state
);

   // Handshake: start is accepted only on an edge where the block is IDLE
   // (busy=0); busy stays high through RUN and DONE; done pulses for the
   // single DONE cycle, after which D/Bout hold until the next accepted start.

   localparam int N_STEPS = steps(WIDTH);
   localparam int STEP_W  = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_STEPS - 1);

   state_e             state_q, state_d;
   logic [STEP_W-1:0]  step_q,  step_d;
   logic [WIDTH-1:0]   a_q,     a_d;
   logic [WIDTH-1:0]   b_q,     b_d;
   logic               brw_q,   brw_d;
   logic [WIDTH-1:0]   d_q,     d_d;
   logic               bout_q,  bout_d;
   logic               v_q,     v_d;

   logic [SLICE_W-1:0] s_a;
   logic [SLICE_W-1:0] s_b;
   logic [SLICE_W-1:0] s_d;
   logic               s_bo;

   // Operand registers shift down one nibble per step, so the slice always
   // reads the current nibble from the bottom.
   assign s_a = a_q[SLICE_W-1:0];
   assign s_b = b_q[SLICE_W-1:0];

   borrow_ahead_slice u_slice (
      .a  (s_a),
      .b  (s_b),
      .bi (brw_q),
      .d  (s_d),
      .bo (s_bo)
   );

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      a_d     = a_q;
      b_d     = b_q;
      brw_d   = brw_q;
      d_d     = d_q;
      bout_d  = bout_q;
      v_d     = v_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = A;
               b_d     = B;
               brw_d   = Bin;
               step_d  = '0;
               d_d     = '0;
               bout_d  = 1'b0;
               v_d     = 1'b0;
               state_d = RUN;
            end
         end

         RUN: begin
            a_d    = a_q >> SLICE_W;
            b_d    = b_q >> SLICE_W;
            brw_d  = s_bo;
            step_d = step_q + STEP_W'(1);
            for (int i = 0; i < N_STEPS; i++) begin
               if (step_q == STEP_W'(i)) begin
                  d_d[i*SLICE_W +: SLICE_W] = s_d;
               end
            end
            if (step_q == LAST_STEP) begin
               // Top nibble: slice bit 3 is the operand/result sign bit.
               bout_d  = s_bo;
               v_d     = (s_a[SLICE_W-1] ^ s_b[SLICE_W-1])
                       & (s_d[SLICE_W-1] ^ s_a[SLICE_W-1]);
               state_d = DONE;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         step_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         brw_q   <= 1'b0;
         d_q     <= '0;
         bout_q  <= 1'b0;
         v_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         a_q     <= a_d;
         b_q     <= b_d;
         brw_q   <= brw_d;
         d_q     <= d_d;
         bout_q  <= bout_d;
         v_q     <= v_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign D         = d_q;
   assign Bout      = bout_q;
   assign dbg_state = state_q;

`ifdef BORROW_AHEAD_SUB_SEQ_OVF_EN
   assign V = v_q;
`else
   logic unused_v;
   assign unused_v = v_q;
`endif

endmodule

// File: tb/tb_borrow_ahead_sub_seq.sv
// Directed self-checking bench for borrow_ahead_sub_seq (WIDTH=16).
module tb_borrow_ahead_sub_seq;

   localparam int W = 16;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         Bin;
   logic         busy;
   logic         done;
   logic [W-1:0] D;
   logic         Bout;
   logic [1:0]   dbg_state;
`ifdef BORROW_AHEAD_SUB_SEQ_OVF_EN
   logic         V;
`endif

   int checks;
   int errors;

   borrow_ahead_sub_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .A         (A),
      .B         (B),
      .Bin       (Bin),
      .busy      (busy),
      .done      (done),
      .D         (D),
      .Bout      (Bout),
`ifdef BORROW_AHEAD_SUB_SEQ_OVF_EN
      .V         (V),
`endif
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge; inputs change and outputs are sampled 1ns after it.
   task automatic step_clk();
      @(posedge clk);
      #1;
   endtask

   // ---------------- driver tasks ----------------
   // Present operands with start for one edge (the accepting edge when IDLE).
   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
      A     = a;
      B     = b;
      Bin   = bi;
      start = 1'b1;
      step_clk();
      start = 1'b0;
   endtask

   // Wait up to 20 edges for done; reports whether it was seen.
   task automatic wait_done(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         step_clk();
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      A = '0; B = '0; Bin = 1'b0;
      step_clk();
      step_clk();
      rst_n = 1'b1;
      A = 16'h1234;
      step_clk();
      checks++;
      if (D !== 16'h0000 || Bout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: D=%h Bout=%b busy=%b done=%b, want D=0000 Bout=0 busy=0 done=0",
                  D, Bout, busy, done);
      end
   endtask

   task automatic test_basic_latency();
      logic exp_busy, exp_done;
      launch(16'h1234, 16'h0234, 1'b0);
      // j=0 is right after the accepting edge: four RUN cycles, then DONE, then IDLE.
      for (int j = 0; j < 6; j++) begin
         exp_busy = (j <= 4);
         exp_done = (j == 4);
         checks++;
         if (busy !== exp_busy || done !== exp_done) begin
            errors++;
            $display("FAIL latency_cycle%0d: busy=%b done=%b, want busy=%b done=%b",
                     j, busy, done, exp_busy, exp_done);
         end
         if (j == 4) begin
            checks++;
            if (D !== 16'h1000 || Bout !== 1'b0) begin
               errors++;
               $display("FAIL basic_result: D=%h Bout=%b, want D=1000 Bout=0", D, Bout);
            end
         end
         step_clk();
      end
      checks++;
      if (D !== 16'h1000) begin
         errors++;
         $display("FAIL basic_hold: D=%h, want 1000", D);
      end
   endtask

   task automatic test_wrap_borrow();
      logic [W-1:0] ta [3];
      logic [W-1:0] tb [3];
      logic         tbi[3];
      logic [W-1:0] ed [3];
      logic         eb [3];
      bit           seen;
      ta[0] = 16'h0000; tb[0] = 16'h0001; tbi[0] = 1'b0; ed[0] = 16'hFFFF; eb[0] = 1'b1;
      ta[1] = 16'h0005; tb[1] = 16'h0005; tbi[1] = 1'b1; ed[1] = 16'hFFFF; eb[1] = 1'b1;
      ta[2] = 16'hFFFF; tb[2] = 16'hFFFF; tbi[2] = 1'b0; ed[2] = 16'h0000; eb[2] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         launch(ta[i], tb[i], tbi[i]);
         wait_done(seen);
         checks++;
         if (!seen || D !== ed[i] || Bout !== eb[i]) begin
            errors++;
            $display("FAIL wrap_%0d: seen=%b D=%h Bout=%b, want seen=1 D=%h Bout=%b",
                     i, seen, D, Bout, ed[i], eb[i]);
         end
         step_clk();
      end
   endtask

   task automatic test_busy_rules();
      int           n_done;
      logic [W-1:0] got_d;
      logic         got_b;
      bit           seen;
      n_done = 0;
      got_d  = '0;
      got_b  = 1'b0;
      launch(16'h5678, 16'h1111, 1'b0);
      // Start is presented at edges 2 (RUN) and 5 (DONE); operands scrambled.
      for (int j = 1; j <= 10; j++) begin
         start = (j == 2 || j == 5);
         A     = 16'($urandom_range(0, 16'hFFFF));
         B     = 16'($urandom_range(0, 16'hFFFF));
         Bin   = 1'($urandom_range(0, 1));
         step_clk();
         if (done) begin
            n_done++;
            got_d = D;
            got_b = Bout;
         end
      end
      start = 1'b0;
      checks++;
      if (n_done !== 1) begin
         errors++;
         $display("FAIL busy_done_count: got %0d, want 1", n_done);
      end
      checks++;
      if (got_d !== 16'h4567 || got_b !== 1'b0) begin
         errors++;
         $display("FAIL busy_captured: D=%h Bout=%b, want D=4567 Bout=0", got_d, got_b);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_no_queue: busy=%b, want 0", busy);
      end
      launch(16'h00FF, 16'h0100, 1'b0);
      wait_done(seen);
      checks++;
      if (!seen || D !== 16'hFFFF || Bout !== 1'b1) begin
         errors++;
         $display("FAIL busy_next_op: seen=%b D=%h Bout=%b, want seen=1 D=ffff Bout=1",
                  seen, D, Bout);
      end
      step_clk();
   endtask

   task automatic test_reset_mid_op();
      int n_done;
      bit seen;
      n_done = 0;
      launch(16'h9999, 16'h1111, 1'b0);
      step_clk();
      rst_n = 1'b0;
      step_clk();
      rst_n = 1'b1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || D !== 16'h0000 || Bout !== 1'b0) begin
         errors++;
         $display("FAIL abort_state: busy=%b done=%b D=%h Bout=%b, want 0 0 0000 0",
                  busy, done, D, Bout);
      end
      for (int j = 0; j < 8; j++) begin
         step_clk();
         if (done) n_done++;
      end
      checks++;
      if (n_done !== 0) begin
         errors++;
         $display("FAIL abort_no_done: got %0d done pulses, want 0", n_done);
      end
      launch(16'h9999, 16'h1111, 1'b0);
      wait_done(seen);
      checks++;
      if (!seen || D !== 16'h8888 || Bout !== 1'b0) begin
         errors++;
         $display("FAIL abort_recover: seen=%b D=%h Bout=%b, want seen=1 D=8888 Bout=0",
                  seen, D, Bout);
      end
      step_clk();
   endtask

   task automatic test_back_to_back();
      int done_at[$];
      A     = 16'h9000;
      B     = 16'h0001;
      Bin   = 1'b0;
      start = 1'b1;
      for (int j = 0; j < 20; j++) begin
         step_clk();
         if (done) begin
            done_at.push_back(j);
            checks++;
            if (D !== 16'h8FFF || Bout !== 1'b0) begin
               errors++;
               $display("FAIL b2b_result: D=%h Bout=%b, want D=8fff Bout=0", D, Bout);
            end
         end
      end
      start = 1'b0;
      checks++;
      if (done_at.size() < 3) begin
         errors++;
         $display("FAIL b2b_count: got %0d results, want at least 3", done_at.size());
      end else begin
         checks++;
         if (done_at[1] - done_at[0] !== 6 || done_at[2] - done_at[1] !== 6) begin
            errors++;
            $display("FAIL b2b_period: got %0d and %0d cycles, want 6",
                     done_at[1] - done_at[0], done_at[2] - done_at[1]);
         end
      end
      for (int j = 0; j < 3; j++) step_clk();
   endtask

`ifdef BORROW_AHEAD_SUB_SEQ_OVF_EN
   task automatic test_overflow();
      logic [W-1:0] ta[3];
      logic [W-1:0] tb[3];
      logic [W-1:0] ed[3];
      logic         ev[3];
      logic         eb[3];
      bit           seen;
      ta[0] = 16'h8000; tb[0] = 16'h0001; ed[0] = 16'h7FFF; ev[0] = 1'b1; eb[0] = 1'b0;
      ta[1] = 16'h7FFF; tb[1] = 16'hFFFF; ed[1] = 16'h8000; ev[1] = 1'b1; eb[1] = 1'b1;
      ta[2] = 16'h0003; tb[2] = 16'h0001; ed[2] = 16'h0002; ev[2] = 1'b0; eb[2] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         launch(ta[i], tb[i], 1'b0);
         wait_done(seen);
         checks++;
         if (!seen || D !== ed[i] || V !== ev[i] || Bout !== eb[i]) begin
            errors++;
            $display("FAIL ovf_%0d: seen=%b D=%h V=%b Bout=%b, want seen=1 D=%h V=%b Bout=%b",
                     i, seen, D, V, Bout, ed[i], ev[i], eb[i]);
         end
         step_clk();
      end
   endtask
`endif

   // ---------------- sequence and report ----------------
   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic_latency();
      test_wrap_borrow();
      test_busy_rules();
      test_reset_mid_op();
      test_back_to_back();
`ifdef BORROW_AHEAD_SUB_SEQ_OVF_EN
      test_overflow();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
